sequence_player: RTL and testbench

- Playback controller for the Genius game. It replays the stored colour sequence on the four LEDs after the game controller requests it.
- Reads colour codes one by one from the sequence memory through a read port with 1-cycle latency. Times each LED's on and off phases by the latched speed setting.
- Sits between the game controller (start/abort/done handshake) and the sequence RAM plus the LED outputs.

---
 rtl/sequence_player_if.sv | 29 ++
 rtl/sequence_player.sv | 104 ++++++++++
 tb/tb_sequence_player.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sequence_player_if.sv
// sequence_player_if: controller, sequence-memory and LED signals of the Genius playback block
// slave  : the player (takes play requests and read data, drives memory strobe/address, LEDs, status)
// master : the game controller plus sequence memory side
interface sequence_player_if #(
  parameter int COLOR_CODEFY_W = 2,
  parameter int ADDR_WIDTH     = 5
);
  logic                      play_start;
  logic [ADDR_WIDTH-1:0]     play_len;
  logic                      speed;
  logic                      abort;
  logic                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [COLOR_CODEFY_W-1:0] mem_rd_data;
  logic                      led_green;
  logic                      led_red;
  logic                      led_blue;
  logic                      led_yellow;
  logic                      busy;
  logic                      done;
  modport slave (
    input  play_start, play_len, speed, abort, mem_rd_data,
    output mem_rd_en, mem_addr, led_green, led_red, led_blue, led_yellow, busy, done
  );
  modport master (
    output play_start, play_len, speed, abort, mem_rd_data,
    input  mem_rd_en, mem_addr, led_green, led_red, led_blue, led_yellow, busy, done
  );
endinterface

// File: rtl/sequence_player.sv
// sequence_player: replays the stored Genius colour sequence on four LEDs with speed-dependent on/gap timing
// clk, rst : clock, asynchronous active-high reset
// bus      : slave side of sequence_player_if (play_start/play_len/speed/abort in, memory read port,
//            led_green/red/blue/yellow, busy and a one-cycle done pulse out); all outputs are flops
module sequence_player #(
  parameter int COLOR_CODEFY_W = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int CNT_W          = 24,
  parameter int ON_SLOW        = 50000000,
  parameter int OFF_SLOW       = 25000000,
  parameter int ON_FAST        = 25000000,
  parameter int OFF_FAST       = 12500000
) (
  input  logic clk,
  input  logic rst,
  sequence_player_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, SHOW, GAP, DONE} state_t;
  localparam logic [CNT_W-1:0] ON_S1  = CNT_W'(ON_SLOW - 1);
  localparam logic [CNT_W-1:0] OFF_S1 = CNT_W'(OFF_SLOW - 1);
  localparam logic [CNT_W-1:0] ON_F1  = CNT_W'(ON_FAST - 1);
  localparam logic [CNT_W-1:0] OFF_F1 = CNT_W'(OFF_FAST - 1);
  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     len_q, len_d, idx_q, idx_d, addr_q, addr_d;
  logic                      speed_q, speed_d;
  logic [COLOR_CODEFY_W-1:0] color_q, color_d;
  logic [CNT_W-1:0]          timer_q, timer_d;
  logic [3:0]                led_q, led_d;
  logic                      rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    speed_d = speed_q;
    idx_d   = idx_q;
    color_d = color_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (bus.play_start && !bus.abort) begin
        len_d   = bus.play_len;
        speed_d = bus.speed;
        idx_d   = '0;
        state_d = (bus.play_len == '0) ? DONE : FETCH;
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        color_d = bus.mem_rd_data;
        timer_d = speed_q ? ON_F1 : ON_S1;
        state_d = SHOW;
      end
      SHOW: begin
        timer_d = (timer_q == '0) ? (speed_q ? OFF_F1 : OFF_S1) : timer_q - 1'b1;
        state_d = (timer_q == '0) ? GAP : SHOW;
      end
      GAP: if (timer_q == '0) begin
        state_d = (idx_q == len_q - 1'b1) ? DONE : FETCH;
        idx_d   = (idx_q == len_q - 1'b1) ? idx_q : idx_q + 1'b1;
      end else
        timer_d = timer_q - 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
    // outputs are registered: decode them from the state we are about to enter
    rd_en_d = (state_d == FETCH);
    addr_d  = (state_d == FETCH) ? idx_d : addr_q;
    busy_d  = (state_d == FETCH) || (state_d == WAIT_DATA) || (state_d == SHOW) || (state_d == GAP);
    done_d  = (state_d == DONE);
    led_d   = (state_d == SHOW) ? 4'b0001 << color_d : 4'b0000;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      speed_q <= 1'b0;
      idx_q   <= '0;
      color_q <= '0;
      timer_q <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      speed_q <= speed_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.led_green  = led_q[0];
  assign bus.led_red    = led_q[1];
  assign bus.led_blue   = led_q[2];
  assign bus.led_yellow = led_q[3];
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: table-driven and randomized playback runs checked cycle by cycle against a schedule model
module tb_sequence_player;
  localparam int ONF = 3, OFFF = 2, ONS = 6, OFFS = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0, n_fail = 0;
  logic [1:0] mem [32];
  int cur_len, cur_on, cur_off, cur_ab;
  logic [4:0] prev_addr = '0;
  typedef struct {
    int         len;
    bit         spd;
    int         ab;
    bit         junk;
    logic [5:0] codes;
    int         exp_done;
  } vec_t;
  vec_t tbl [7];
  sequence_player_if #(.COLOR_CODEFY_W(2), .ADDR_WIDTH(5)) bus ();
  sequence_player #(
    .COLOR_CODEFY_W(2), .ADDR_WIDTH(5), .CNT_W(24),
    .ON_SLOW(ONS), .OFF_SLOW(OFFS), .ON_FAST(ONF), .OFF_FAST(OFFF)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [11:0] actual();
    return {bus.led_yellow, bus.led_blue, bus.led_red, bus.led_green, bus.mem_rd_en, bus.mem_addr, bus.busy, bus.done};
  endfunction
  // expected outputs d cycles after the accepting edge: each entry occupies a period of 2+ON+OFF
  // cycles (fetch, wait, ON lit cycles, OFF dark cycles), done follows the last period
  function automatic logic [11:0] model(int d);
    int p, lim, nf, i, r;
    logic [3:0] led;
    logic rd, bs, dn;
    logic [4:0] a;
    bit killed;
    p = 2 + cur_on + cur_off;
    led = '0; rd = 0; bs = 0; dn = 0;
    killed = cur_ab > 0 && d > cur_ab;
    lim = killed ? cur_ab : d;
    nf = (lim - 1) / p + 1;
    if (nf > cur_len) nf = cur_len;
    a = nf > 0 ? 5'(nf - 1) : prev_addr;
    if (!killed) begin
      if (cur_len == 0) dn = (d == 1);
      else if (d <= cur_len * p) begin
        i = (d - 1) / p;
        r = (d - 1) % p;
        bs = 1;
        rd = (r == 0);
        if (r >= 2 && r < 2 + cur_on) led = 4'b0001 << mem[i];
      end else dn = (d == cur_len * p + 1);
    end
    return {led, rd, a, bs, dn};
  endfunction
  task automatic run(input int len, input bit spd, input int ab, input bit junk, input int exp_done);
    int p, last, seen;
    logic [11:0] m;
    cur_len = len;
    cur_on  = spd ? ONF : ONS;
    cur_off = spd ? OFFF : OFFS;
    cur_ab  = ab;
    p = 2 + cur_on + cur_off;
    last = len * p + 3;
    seen = 0;
    @(negedge clk);
    bus.play_start = 1'b1; bus.play_len = 5'(len); bus.speed = spd; bus.abort = 1'b0;
    @(posedge clk);
    for (int d = 1; d <= last; d++) begin
      @(negedge clk);
      m = model(d);
      check($sformatf("cycle len=%0d spd=%0d d=%0d", len, spd, d), 32'(actual()), 32'(m));
      if (bus.done && seen == 0) seen = d;
      bus.play_start = (junk && ab == 0 && d <= len * p + 1) ? 1'($urandom) : 1'b0;
      if (junk) begin
        bus.speed = 1'($urandom);
        bus.play_len = 5'($urandom);
      end
      bus.abort = (d == ab);
    end
    bus.play_start = 1'b0;
    bus.abort = 1'b0;
    if (exp_done >= 0) check($sformatf("done_cycle len=%0d", len), 32'(seen), 32'(exp_done));
    m = model(last);
    prev_addr = m[6:2];
  endtask
  initial begin
    tbl[0] = '{3, 1'b1, 0,  1'b0, 6'b100100, 22};
    tbl[1] = '{1, 1'b0, 0,  1'b1, 6'b000011, 13};
    tbl[2] = '{0, 1'b1, 0,  1'b0, 6'b000000, 1};
    tbl[3] = '{3, 1'b1, 11, 1'b0, 6'b100100, 0};
    tbl[4] = '{3, 1'b1, 0,  1'b0, 6'b100100, 22};
    tbl[5] = '{3, 1'b1, 0,  1'b1, 6'b100100, 22};
    tbl[6] = '{2, 1'b0, 0,  1'b0, 6'b001101, 25};
    bus.play_start = 1'b0; bus.play_len = '0; bus.speed = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(actual()), 32'd0);
    rst = 1'b0;
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 3; i++) mem[i] = tbl[t].codes[2*i +: 2];
      run(tbl[t].len, tbl[t].spd, tbl[t].ab, tbl[t].junk, tbl[t].exp_done);
    end
    @(negedge clk);
    bus.play_start = 1'b1; bus.play_len = 5'd3; bus.abort = 1'b1;
    @(negedge clk);
    bus.play_start = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_beats_start %0d", i), 32'(actual()), 32'({4'b0, 1'b0, prev_addr, 2'b00}));
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) mem[i] = 2'(i);
    bus.play_start = 1'b1; bus.play_len = 5'd3; bus.speed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.play_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_show", 32'(actual()), 32'({4'b0001, 1'b0, 5'd0, 2'b10}));
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(actual()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_addr = '0;
    run(3, 1'b1, 0, 1'b0, 22);
    for (int k = 0; k < 12; k++) begin
      int len, p;
      bit spd;
      len = $urandom_range(0, 31);
      spd = 1'($urandom);
      p = spd ? 2 + ONF + OFFF : 2 + ONS + OFFS;
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
      run(len, spd, (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len * p)) : 0, 1'($urandom), -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
